// File: rtl/layer1_pkg.sv
// Shared layer-1 geometry and the address-generator state encoding.
// Everything layer-1 derives its widths and limits from here.
package layer1_pkg;

    localparam int IMG_W   = 32;
    localparam int IMG_H   = 32;
    localparam int K       = 3;
    localparam int STRIDE  = 1;
    localparam int OUT_W   = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H   = (IMG_H - K) / STRIDE + 1;
    localparam int ADDR_W  = 10;
    localparam int WADDR_W = 4;

    localparam int KC_W = $clog2(K);
    localparam int XC_W = $clog2(OUT_W);
    localparam int YC_W = $clog2(OUT_H);

    typedef logic [1:0] l1_agen_state_t;
    localparam l1_agen_state_t IDLE = 2'd0;
    localparam l1_agen_state_t RUN  = 2'd1;
    localparam l1_agen_state_t FIN  = 2'd2;

endpackage

// File: rtl/conv_addr_gen_l1_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the enabled step
// that returns the count to zero, so counters chain by wiring wrap to en.
module wrap_counter_l1 #(
    parameter int WIDTH = 2,
    parameter int MAX   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign wrap = en && (cnt == MAX_V);

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/conv_addr_gen_l1.sv
// Layer-1 sliding-window address generator: walks taps j,k inside each output
// pixel x,y and registers feature-map / weight addresses, freezing on stall.
module conv_addr_gen_l1
    import layer1_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    output logic [ADDR_W-1:0]  fm_addr,
    output logic [WADDR_W-1:0] w_addr,
    output logic               addr_valid,
    output logic               x_zero,
    output logic               busy,
    output logic               done
);

    localparam int AW2 = ADDR_W + 2;
    localparam int WW2 = WADDR_W + 2;
    localparam logic [AW2-1:0] IMG_W_V  = AW2'(IMG_W);
    localparam logic [AW2-1:0] STRIDE_V = AW2'(STRIDE);
    localparam logic [WW2-1:0] K_V      = WW2'(K);

    l1_agen_state_t state;

    logic [KC_W-1:0] j, k;
    logic [XC_W-1:0] x;
    logic [YC_W-1:0] y;
    logic            j_wrap, k_wrap, x_wrap, y_wrap;
    logic            advance, clr;

    logic [AW2-1:0]     row, col, fm_sum;
    logic [WW2-1:0]     w_sum;
    logic [ADDR_W-1:0]  fm_next;
    logic [WADDR_W-1:0] w_next;

    assign advance = (state == RUN) && !stall;
    assign clr     = (state == IDLE) && start;
    assign busy    = (state == RUN);

    // k_wrap marks a window's last tap; y_wrap marks the frame's last tap.
    wrap_counter_l1 #(.WIDTH(KC_W), .MAX(K - 1)) u_cnt_j (
        .clk(clk), .rst(rst), .en(advance), .clr(clr), .cnt(j), .wrap(j_wrap)
    );
    wrap_counter_l1 #(.WIDTH(KC_W), .MAX(K - 1)) u_cnt_k (
        .clk(clk), .rst(rst), .en(j_wrap), .clr(clr), .cnt(k), .wrap(k_wrap)
    );
    wrap_counter_l1 #(.WIDTH(XC_W), .MAX(OUT_W - 1)) u_cnt_x (
        .clk(clk), .rst(rst), .en(k_wrap), .clr(clr), .cnt(x), .wrap(x_wrap)
    );
    wrap_counter_l1 #(.WIDTH(YC_W), .MAX(OUT_H - 1)) u_cnt_y (
        .clk(clk), .rst(rst), .en(x_wrap), .clr(clr), .cnt(y), .wrap(y_wrap)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        row     = '0;
        col     = '0;
        fm_sum  = '0;
        w_sum   = '0;
        row     = AW2'(y) * STRIDE_V + AW2'(k);
        col     = AW2'(x) * STRIDE_V + AW2'(j);
        fm_sum  = row * IMG_W_V + col;
        w_sum   = WW2'(k) * K_V + WW2'(j);
        fm_next = fm_sum[ADDR_W-1:0];
        w_next  = w_sum[WADDR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fm_addr    <= '0;
            w_addr     <= '0;
            addr_valid <= 1'b0;
            x_zero     <= 1'b0;
            done       <= 1'b0;
        end else begin
            addr_valid <= 1'b0;
            x_zero     <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (advance) begin
                        fm_addr    <= fm_next;
                        w_addr     <= w_next;
                        addr_valid <= 1'b1;
                        x_zero     <= k_wrap;
                        if (y_wrap) state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_addr_gen_l1.sv
// Directed bench for conv_addr_gen_l1: expected taps are queued at each start
// and popped whenever the generator presents a valid address.
module tb_conv_addr_gen_l1;

    localparam int TB_IMG_W = 32;
    localparam int TB_OUT   = 30;
    localparam int TB_K     = 3;
    localparam int FRAME    = TB_OUT * TB_OUT * TB_K * TB_K;

    typedef struct packed {
        logic [9:0] fm;
        logic [3:0] w;
        logic       xz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic [9:0] fm_addr;
    logic [3:0] w_addr;
    logic       addr_valid, x_zero, busy, done;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_valid, n_xz, n_done, last_valid_cyc;
    logic [9:0] last_fm;
    logic [3:0] last_w;

    conv_addr_gen_l1 dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .fm_addr(fm_addr), .w_addr(w_addr), .addr_valid(addr_valid),
        .x_zero(x_zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        for (int y = 0; y < TB_OUT; y++)
            for (int x = 0; x < TB_OUT; x++)
                for (int k = 0; k < TB_K; k++)
                    for (int j = 0; j < TB_K; j++) begin
                        exp_t e;
                        e.fm = 10'((y + k) * TB_IMG_W + x + j);
                        e.w  = 4'(k * TB_K + j);
                        e.xz = (k == TB_K - 1) && (j == TB_K - 1);
                        sb.push_back(e);
                    end
    endtask

    task automatic clear_counts();
        n_valid = 0; n_xz = 0; n_done = 0; last_valid_cyc = 0;
        last_fm = '0; last_w = '0;
    endtask

    // One clock step; outputs are observed on the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (addr_valid) begin
            check("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("fm_addr", 32'(fm_addr), 32'(e.fm));
                check("w_addr", 32'(w_addr), 32'(e.w));
                check("x_zero", 32'(x_zero), 32'(e.xz));
            end
            n_valid++;
            if (x_zero) n_xz++;
            last_fm = fm_addr;
            last_w  = w_addr;
            last_valid_cyc = cyc;
        end else if (x_zero) begin
            check("x_zero_without_valid", 32'(x_zero), 0);
        end
        if (done) begin
            n_done++;
            check("done_latency", 32'(cyc - last_valid_cyc), 1);
            check("busy_at_done", 32'(busy), 0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_valid(input int target, input int budget);
        int n = 0;
        while (n_valid < target && n < budget) begin
            tick();
            n++;
        end
        check("valid_count_reached", 32'(n_valid), 32'(target));
    endtask

    initial begin
        int   tc;
        int   n;
        logic [9:0] held;

        clear_counts();
        repeat (2) tick();
        check("rst_fm_addr", 32'(fm_addr), 0);
        check("rst_w_addr", 32'(w_addr), 0);
        check("rst_addr_valid", 32'(addr_valid), 0);
        check("rst_x_zero", 32'(x_zero), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b1;
        tick();

        // Stall in IDLE must not launch anything.
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        tick();
        check("idle_stall_busy", 32'(busy), 0);
        check("idle_stall_valid", 32'(n_valid), 0);

        // First window and the start of the second.
        push_frame();
        pulse_start();
        tick();
        check("busy_in_run", 32'(busy), 1);
        run_until_valid(9, 50);
        check("first_window_xz", 32'(n_xz), 1);
        run_until_valid(18, 50);
        check("second_window_xz", 32'(n_xz), 2);
        check("second_xz_fm", 32'(fm_addr), 67);

        // Stall raised in the x_zero cycle: the pulse stands, the next tap waits.
        held = fm_addr;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid_low", 32'(addr_valid), 0);
            check("stall_fm_held", 32'(fm_addr), 32'(held));
        end
        stall = 1'b0;
        run_until_valid(30, 50);

        // Start pulses while running are ignored.
        pulse_start();
        tick();
        pulse_start();
        check("start_in_run_busy", 32'(busy), 1);

        // Rest of the frame with a 4-cycle temp phase after every window.
        tc = 0;
        n = 0;
        while (n_done == 0 && n < 20000) begin
            tick();
            if (x_zero) tc = 4;
            stall = (tc > 0);
            if (tc > 0) tc--;
            n++;
        end
        stall = 1'b0;
        repeat (5) tick();
        check("frame_done_count", 32'(n_done), 1);
        check("frame_valid_count", 32'(n_valid), 32'(FRAME));
        check("frame_xz_count", 32'(n_xz), 32'(TB_OUT * TB_OUT));
        check("frame_last_fm", 32'(last_fm), 1023);
        check("frame_last_w", 32'(last_w), 8);
        check("frame_sb_drained", 32'(sb.size()), 0);
        check("frame_busy_low", 32'(busy), 0);

        // Reset mid-scan clears outputs at once and never reports done.
        clear_counts();
        push_frame();
        pulse_start();
        run_until_valid(500, 1000);
        #1 rst = 1'b0;
        #1;
        check("abort_fm_addr", 32'(fm_addr), 0);
        check("abort_w_addr", 32'(w_addr), 0);
        check("abort_valid", 32'(addr_valid), 0);
        check("abort_x_zero", 32'(x_zero), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        sb.delete();
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("abort_no_done", 32'(n_done), 0);
        check("abort_idle", 32'(busy), 0);

        // Fresh start begins again at address 0.
        clear_counts();
        push_frame();
        pulse_start();
        run_until_valid(20, 60);
        check("restart_xz", 32'(n_xz), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
